tx_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one UART transmitter (tx: Start, SWIn, TXD, TX_BUSY) between N byte producers.

---
 rtl/tx_arbiter.sv | 136 +++++++++++++
 tb/tb_tx_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte producers.
// Latches the winning byte, drives Start into tx, follows TX_BUSY through the frame and returns ACK/ERR.
module tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int START_TO = 16
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*DATA_W-1:0] DATA,
    output logic [N_REQ-1:0]        GNT,
    output logic [N_REQ-1:0]        ACK,
    output logic                    ERR,
    output logic                    TX_START,
    output logic [DATA_W-1:0]       TX_DATA,
    input  logic                    TX_BUSY
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(START_TO);

    typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;

    logic [DATA_W-1:0]    data_arr [N_REQ];
    logic                 found;
    logic [PTR_W-1:0]     win;
    logic [PTR_W-1:0]     idx_w;
    int                   idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = DATA[g*DATA_W +: DATA_W];
    end

    // Search ptr+1, ptr+2, ... so the last winner has lowest priority next time.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = 0;
        idx_w = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx   = (int'(ptr_q) + i) % N_REQ;
            idx_w = PTR_W'(idx);
            if (!found && REQ[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        err_d      = 1'b0;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                // A frame still running (e.g. from before reset) blocks new grants.
                if (found && !TX_BUSY) begin
                    gnt_d      = N_REQ'(1) << win;
                    tx_data_d  = data_arr[win];
                    tx_start_d = 1'b1;
                    ptr_d      = win;
                    cnt_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (TX_BUSY) begin
                    tx_start_d = 1'b0;
                    state_d    = SEND;
                end else if (cnt_q == CNT_W'(START_TO - 1)) begin
                    tx_start_d = 1'b0;
                    gnt_d      = '0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (!TX_BUSY) begin
                    gnt_d   = '0;
                    ack_d   = N_REQ'(1) << ptr_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(N_REQ - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign GNT      = gnt_q;
    assign ACK      = ack_q;
    assign ERR      = err_q;
    assign TX_START = tx_start_q;
    assign TX_DATA  = tx_data_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: tx model raises TX_BUSY one cycle after Start and holds it ~100 cycles.
// Expected (requester, byte) pairs are queued as requests are driven and checked on each ACK.
module tb_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           CLK  = 1'b0;
    logic           RSTn = 1'b0;
    logic [N-1:0]   REQ  = '0;
    logic [N*W-1:0] DATA = '0;
    logic [N-1:0]   GNT, ACK;
    logic           ERR, TX_START;
    logic [W-1:0]   TX_DATA;
    logic           TX_BUSY = 1'b0;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic       model_en  = 1'b1;
    int         busy_cnt  = 0;
    logic [7:0] last_byte = 8'h00;

    tx_arbiter #(.N_REQ(N), .DATA_W(W), .START_TO(TO)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .DATA(DATA), .GNT(GNT), .ACK(ACK),
        .ERR(ERR), .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY)
    );

    always #5 CLK = ~CLK;

    // tx model: independent of RSTn so a frame survives an arbiter reset.
    always @(posedge CLK) begin
        if (TX_BUSY) begin
            if (busy_cnt <= 1) TX_BUSY <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (model_en && TX_START) begin
            TX_BUSY   <= 1'b1;
            busy_cnt  <= 100;
            last_byte <= TX_DATA;
        end
    end

    task automatic apply_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        REQ  = '0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic wait_ack(output int idx);
        idx = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (ACK != '0) begin
                for (int j = 0; j < N; j++) if (ACK[j]) idx = j;
                return;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++;
        if ({GNT, ACK, ERR, TX_START, TX_DATA} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b ack=%b err=%b start=%b data=%h want all 0",
                     GNT, ACK, ERR, TX_START, TX_DATA);
        end
    endtask

    task automatic test_single();
        int   a;
        exp_t e;
        apply_reset();
        DATA[7:0] = 8'hAC;
        REQ       = 4'b0001;
        exp_q.push_back('{0, 8'hAC});
        @(negedge CLK);
        total++;
        if (GNT !== 4'b0001 || TX_DATA !== 8'hAC || TX_START !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got gnt=%b data=%h start=%b want 0001 ac 1", GNT, TX_DATA, TX_START);
        end
        wait_ack(a);
        e = exp_q.pop_front();
        REQ = '0;
        total++;
        if (ACK !== (N'(1) << e.idx)) begin
            bad++;
            $display("FAIL single_ack got %b want idx %0d", ACK, e.idx);
        end
        total++;
        if (last_byte !== e.data) begin
            bad++;
            $display("FAIL single_byte got %h want %h", last_byte, e.data);
        end
        @(negedge CLK);
        total++;
        if (ACK !== 4'b0000 || GNT !== 4'b0000) begin
            bad++;
            $display("FAIL single_ack_pulse got ack=%b gnt=%b want 0000 0000", ACK, GNT);
        end
    endtask

    task automatic test_round_robin();
        int   a;
        exp_t e;
        apply_reset();
        DATA = {8'h44, 8'h33, 8'h22, 8'h11};
        REQ  = 4'b1111;
        exp_q.push_back('{0, 8'h11});
        exp_q.push_back('{1, 8'h22});
        exp_q.push_back('{2, 8'h33});
        exp_q.push_back('{3, 8'h44});
        exp_q.push_back('{0, 8'h11});
        for (int k = 0; k < 5; k++) begin
            wait_ack(a);
            e = exp_q.pop_front();
            if (k == 4) REQ = '0;
            total++;
            if (ACK !== (N'(1) << e.idx)) begin
                bad++;
                $display("FAIL rr_ack[%0d] got %b want idx %0d", k, ACK, e.idx);
            end
            total++;
            if (last_byte !== e.data) begin
                bad++;
                $display("FAIL rr_byte[%0d] got %h want %h", k, last_byte, e.data);
            end
        end
    endtask

    task automatic test_wrap();
        int   a;
        exp_t e;
        apply_reset();
        DATA = {8'h00, 8'h5A, 8'h00, 8'hA5};
        REQ  = 4'b0100;
        exp_q.push_back('{2, 8'h5A});
        exp_q.push_back('{0, 8'hA5});
        exp_q.push_back('{2, 8'h5A});
        for (int k = 0; k < 3; k++) begin
            wait_ack(a);
            e = exp_q.pop_front();
            REQ = (k == 0) ? 4'b0101 : (k == 1) ? 4'b0100 : 4'b0000;
            total++;
            if (ACK !== (N'(1) << e.idx)) begin
                bad++;
                $display("FAIL wrap_ack[%0d] got %b want idx %0d", k, ACK, e.idx);
            end
            total++;
            if (last_byte !== e.data) begin
                bad++;
                $display("FAIL wrap_byte[%0d] got %h want %h", k, last_byte, e.data);
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 0, errs = 0, acks = 0;
        model_en = 1'b0;
        apply_reset();
        DATA[15:8] = 8'h77;
        REQ        = 4'b0010;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (TX_START) hi++;
            if (ACK != '0) acks++;
            if (ERR) begin
                errs++;
                REQ = '0;
                total++;
                if (TX_START !== 1'b0 || GNT !== 4'b0000) begin
                    bad++;
                    $display("FAIL timeout_err_state got start=%b gnt=%b want 0 0000", TX_START, GNT);
                end
            end
        end
        total++;
        if (hi !== TO) begin
            bad++;
            $display("FAIL timeout_start_len got %0d want %0d", hi, TO);
        end
        total++;
        if (errs !== 1 || acks !== 0) begin
            bad++;
            $display("FAIL timeout_pulses got err=%0d ack=%0d want 1 0", errs, acks);
        end
        total++;
        if (GNT !== 4'b0000 || TX_START !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle got gnt=%b start=%b want 0000 0", GNT, TX_START);
        end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int   a, viol = 0, seen = 0;
        exp_t e;
        apply_reset();
        DATA[7:0] = 8'h3C;
        REQ       = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (GNT[0] && !TX_START && TX_BUSY) break;
        end
        RSTn = 1'b0;
        #1;
        total++;
        if (GNT !== 4'b0000 || TX_START !== 1'b0 || ACK !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_clear got gnt=%b start=%b ack=%b want 0", GNT, TX_START, ACK);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (GNT != '0) begin
                seen = 1;
                if (TX_BUSY) viol++;
                break;
            end
        end
        total++;
        if (seen !== 1 || viol !== 0) begin
            bad++;
            $display("FAIL midreset_wait got seen=%0d early=%0d want 1 0", seen, viol);
        end
        exp_q.push_back('{0, 8'h3C});
        wait_ack(a);
        e = exp_q.pop_front();
        REQ = '0;
        total++;
        if (ACK !== (N'(1) << e.idx) || last_byte !== e.data) begin
            bad++;
            $display("FAIL midreset_ack got ack=%b byte=%h want idx %0d byte %h", ACK, last_byte, e.idx, e.data);
        end
    endtask

    task automatic test_drop_req();
        int   a;
        exp_t e;
        apply_reset();
        DATA[15:8] = 8'hDC;
        REQ        = 4'b0010;
        exp_q.push_back('{1, 8'hDC});
        @(negedge CLK);
        total++;
        if (GNT !== 4'b0010) begin
            bad++;
            $display("FAIL drop_grant got %b want 0010", GNT);
        end
        @(negedge CLK);
        REQ        = 4'b0000;
        DATA[15:8] = 8'h00;
        wait_ack(a);
        e = exp_q.pop_front();
        total++;
        if (ACK !== (N'(1) << e.idx) || last_byte !== e.data) begin
            bad++;
            $display("FAIL drop_ack got ack=%b byte=%h want idx %0d byte %h", ACK, last_byte, e.idx, e.data);
        end
        total++;
        if (TX_DATA !== 8'hDC) begin
            bad++;
            $display("FAIL drop_txdata got %h want dc", TX_DATA);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (GNT !== 4'b0000) begin
            bad++;
            $display("FAIL drop_no_regrant got %b want 0000", GNT);
        end
    endtask

    initial begin
        test_reset();
        RSTn = 1'b1;
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
